// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults and the bit-reversal helper
package fft_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int LOG2N_DEF = 4;
  function automatic logic [15:0] bitrev(input logic [15:0] k, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[4'(i)] = k[4'(n - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_pp_bank.sv
// fft_pp_bank: one ping-pong bank, 2**AW x DW, synchronous write, combinational read
// ports: clk; we/waddr/wdata write port; raddr/rdata read port
module fft_pp_bank #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: converts bit-reversed FFT output frames to natural order via two ping-pong banks
// ports: clk, rst (async, active-high); i_valid/o_ready/i_data_r/i_data_c input stream;
//        o_valid/i_ready/o_data_r/o_data_c/o_last natural-order output stream
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data_r,
  input  logic [WIDTH-1:0] i_data_c,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data_r,
  output logic [WIDTH-1:0] o_data_c,
  output logic             o_last,
  input  logic             i_ready
);
  localparam logic IDLE = 1'b0;
  localparam logic DRAIN = 1'b1;
  localparam logic [LOG2N-1:0] AMAX = '1;
  logic [1:0] full, full_nxt, avail;
  logic wbank, rbank, state, in_fire, wdone, cont, cb, nxt_bank, load, adv;
  logic [LOG2N-1:0] wcnt, waddr, raddr, nxt_addr;
  logic [2*WIDTH-1:0] rdata [2];
  assign o_ready = !full[wbank];
  assign o_valid = state == DRAIN;
  assign in_fire = i_valid && o_ready;
  assign wdone = in_fire && wcnt == AMAX;
  assign waddr = LOG2N'(bitrev(16'(wcnt), LOG2N));
  // a bank completing this edge already holds natural index 0, so it can be presented at once
  assign avail = full | (wdone ? (wbank ? 2'b10 : 2'b01) : 2'b00);
  assign cont = o_valid && !o_last;
  assign cb = o_valid ? !rbank : rbank;
  assign nxt_bank = cont ? rbank : cb;
  assign nxt_addr = cont ? raddr + 1'b1 : '0;
  assign load = cont || avail[cb];
  assign adv = !o_valid || i_ready;
  always_comb begin
    full_nxt = full;
    if (o_valid && i_ready && o_last) full_nxt[rbank] = 1'b0;
    if (wdone) full_nxt[wbank] = 1'b1;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_pp_bank #(.DW(2 * WIDTH), .AW(LOG2N)) u_bank (
      .clk   (clk),
      .we    (in_fire && wbank == 1'(b)),
      .waddr (waddr),
      .wdata ({i_data_r, i_data_c}),
      .raddr (nxt_addr),
      .rdata (rdata[b])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      wbank <= 1'b0;
      wcnt <= '0;
      rbank <= 1'b0;
      raddr <= '0;
      state <= IDLE;
      o_last <= 1'b0;
      o_data_r <= '0;
      o_data_c <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) wcnt <= wcnt + 1'b1;
      if (wdone) wbank <= !wbank;
      if (adv) begin
        state <= load ? DRAIN : IDLE;
        rbank <= nxt_bank;
        o_last <= load && nxt_addr == AMAX;
        if (load) begin
          {o_data_r, o_data_c} <= rdata[nxt_bank];
          raddr <= nxt_addr;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench for fft_bitrev_reorder against a frame-level bit-reversal model
module tb_fft_bitrev_reorder;
  localparam int W = 16;
  localparam int L = 4;
  localparam int N = 16;
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic last;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
  logic [W-1:0] i_data_r = '0, i_data_c = '0;
  logic o_ready, o_valid, o_last;
  logic [W-1:0] o_data_r, o_data_c;
  int vectors = 0, errs = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] fr_r [N];
  logic [W-1:0] fr_c [N];
  int kcnt = 0;
  logic held = 1'b0, hl;
  logic [W-1:0] hr, hc;

  fft_bitrev_reorder #(.WIDTH(W), .LOG2N(L)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_r(i_data_r), .i_data_c(i_data_c),
    .o_ready(o_ready), .o_valid(o_valid), .o_data_r(o_data_r), .o_data_c(o_data_c),
    .o_last(o_last), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int rev(input int n);
    int r = 0;
    int v = n;
    for (int i = 0; i < L; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // the k-th arriving sample holds natural index rev(k); natural index n therefore comes from arrival rev(n)
  task automatic accept_sample(input logic [W-1:0] r, input logic [W-1:0] c);
    fr_r[kcnt] = r;
    fr_c[kcnt] = c;
    kcnt++;
    if (kcnt == N) begin
      for (int n = 0; n < N; n++) q.push_back('{fr_r[rev(n)], fr_c[rev(n)], n == N - 1});
      kcnt = 0;
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] c,
                      input logic rdy, output logic acc);
    i_valid = v;
    i_data_r = r;
    i_data_c = c;
    i_ready = rdy;
    @(negedge clk);
    acc = v && o_ready;
    if (acc) accept_sample(r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data_r", o_data_r, hr);
        chk("hold_data_c", o_data_c, hc);
        chk("hold_last", o_last, hl);
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("out_data_r", o_data_r, mon_e.r);
          chk("out_data_c", o_data_c, mon_e.c);
          chk("out_last", o_last, mon_e.last);
        end
      end
      held = o_valid && !i_ready;
      hr = o_data_r;
      hc = o_data_c;
      hl = o_last;
    end
  end

  initial begin
    logic acc;
    int cnt, gaps, n_acc, first_stall;
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_o_data_r", o_data_r, 0);
    chk("rst_o_data_c", o_data_c, 0);
    chk("rst_o_ready", o_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      step(1'b1, W'(k), W'(-k), 1'b1, acc);
      if (k < N - 1) chk("t1_no_early_valid", o_valid, 0);
    end
    chk("t1_latency_valid", o_valid, 1);
    chk("t1_first_r", o_data_r, 0);
    chk("t1_first_c", o_data_c, 0);
    drain("t1_drain", 40);

    cnt = 0;
    gaps = 0;
    for (int i = 0; i < 3 * N; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b1, acc);
      if (!acc) cnt++;
      if (i >= N - 1 && !o_valid) gaps++;
      if (i == 2 * N - 1) begin
        chk("swap_o_ready", o_ready, 1);
        chk("swap_next_idx0", o_last, 0);
      end
    end
    chk("t2_o_ready_drops", cnt, 0);
    chk("t2_valid_gaps", gaps, 0);
    drain("t2_drain", 60);

    n_acc = 0;
    first_stall = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'b0, acc);
      if (acc) n_acc++;
      else if (first_stall < 0) first_stall = i;
    end
    chk("t3_accepted", n_acc, 32);
    chk("t3_first_stall", first_stall, 32);
    chk("t3_o_ready_low", o_ready, 0);
    drain("t3_drain", 200);

    n_acc = 0;
    for (int i = 0; i < 3000 && n_acc < 10 * N; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), acc);
      if (acc) n_acc++;
    end
    chk("t4_accepted", n_acc, 10 * N);
    drain("t4_drain", 400);

    for (int i = 0; i < N + 7; i++) step(1'b1, W'($urandom), W'($urandom), 1'b1, acc);
    chk("t5_draining_before_rst", o_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_o_valid", o_valid, 0);
    chk("t5_rst_o_ready", o_ready, 1);
    chk("t5_rst_o_last", o_last, 0);
    q.delete();
    kcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) step(1'b1, W'(100 + k), W'(200 + k), 1'b1, acc);
    chk("t5_latency_valid", o_valid, 1);
    chk("t5_first_r", o_data_r, 100);
    drain("t5_drain", 60);

    chk("final_queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 Parameter: WIDTH, default 16, signed sample component width.
REQ-002 Parameter: LOG2N, default 4, log2 of frame length N (N = 16 at default).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 i_valid  input  1  input sample present this cycle.
REQ-006 i_data_r  input  WIDTH  real part of the FFT output sample, arriving in bit-reversed order.
REQ-007 i_data_c  input  WIDTH  imaginary part of the input sample.
REQ-008 o_ready  output  1  block can accept an input sample this cycle.
REQ-009 o_valid  output  1  output sample present this cycle.
REQ-010 o_data_r  output  WIDTH  real part of the output sample, in natural order.
REQ-011 o_data_c  output  WIDTH  imaginary part of the output sample.
REQ-012 o_last  output  1  output sample is natural index N-1 of its frame.
REQ-013 i_ready  input  1  downstream accepts the output sample this cycle.

Function
REQ-014 Input transfer SHALL occur when i_valid && o_ready; output transfer when o_valid && i_ready.
REQ-015 Two banks of N complex entries (ping-pong); one write bank, one read bank; each bank flagged FULL or EMPTY.
REQ-016 k-th accepted sample of a frame (k = 0..N-1) SHALL be stored at bank address bitrev_LOG2N(k).
REQ-017 Write counter wraps N-1 -> 0 on the transfer of the N-th sample; that bank becomes FULL on that edge.
REQ-018 o_ready SHALL be 1 unless the write bank is FULL (both banks FULL -> o_ready = 0, input stalls).
REQ-019 Read side states: IDLE (o_valid = 0) and DRAIN (o_valid = 1); IDLE -> DRAIN when a FULL bank exists; DRAIN presents addresses 0..N-1 in natural order.
REQ-020 Output data SHALL be registered; o_valid, o_data_*, o_last SHALL be held stable while o_valid && !i_ready.
REQ-021 Latency: frame-completing input transfer at edge t with read side IDLE -> o_valid = 1 with index 0 in the cycle after edge t.
REQ-022 Transfer of index N-1 SHALL mark the read bank EMPTY; if the other bank is FULL, index 0 of that bank SHALL be presented the next cycle (no bubble).
REQ-023 Simultaneous frame completion on the write side and final output transfer on the read side SHALL swap banks with no stall of o_ready and no output bubble.
REQ-024 Data SHALL pass unmodified: no scaling, rounding, or sign change.
REQ-025 i_valid while o_ready = 0 SHALL be ignored (no write, no counter advance).

Reset
REQ-026 rst asserted SHALL immediately clear both banks to EMPTY, zero the write counter and read address, and place the read side in IDLE.
REQ-027 Reset values: o_valid = 0, o_last = 0, o_data_r = 0, o_data_c = 0, o_ready = 1 (combinational from EMPTY flags).
REQ-028 Reset mid-frame SHALL discard partial and buffered frames; the first sample after deassertion is k = 0 of a new frame.
REQ-029 Bank memory contents need not be reset.

Structure
REQ-030 Shared package fft_pkg SHALL hold WIDTH and LOG2N defaults and the bitrev function; the butterfly and this block share it.
REQ-031 One sub-module fft_pp_bank (single N x 2*WIDTH bank, one write port, one read port) SHALL be instantiated twice.
REQ-032 Target size 120-400 lines of RTL including the sub-module.

Verification
REQ-033 Single frame, i_data_r = k, i_data_c = -k, i_ready = 1: outputs 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; o_last on the 16th; o_valid one cycle after the 16th input.
REQ-034 Three back-to-back frames, i_ready = 1: 48 contiguous outputs, no o_valid gap, o_ready never 0.
REQ-035 i_ready = 0 for 40 cycles with continuous input: o_ready drops after the 32nd accepted sample; o_data held; order correct after release.
REQ-036 Random i_ready (50%) and random i_valid over 10 frames: output matches the bit-reversed reference model exactly.
REQ-037 rst pulsed after 7 samples of a frame while another frame drains: o_valid = 0 immediately; the next 16 inputs produce one clean frame.
REQ-038 Simultaneous final output transfer and frame completion: next frame index 0 appears the next cycle, o_ready stays 1.
